// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes and FSM states.
package usr_pkg;

   // Operation selected by MODE. A k-bit operation moves the register by k positions.
   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,  // no change
      MODE_SL   = 3'b001,  // shift left, vacated bits take RightIn
      MODE_SR   = 3'b010,  // shift right, vacated bits take LeftIn
      MODE_ROL  = 3'b011,  // rotate left
      MODE_ROR  = 3'b100,  // rotate right
      MODE_ASR  = 3'b101,  // arithmetic shift right, sign bit replicated
      MODE_SL0  = 3'b110,  // shift left, zero fill
      MODE_SR0  = 3'b111   // shift right, zero fill
   } mode_e;

   // Burst engine states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/usr_shifter.sv
// Combinational k-bit shift/rotate unit. Produces the next register value for one
// operation; the fill bit is replicated into every vacated position.
module usr_shifter
   import usr_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0]  q,
   input  mode_e                  mode,
   input  logic [SHAMT_WIDTH-1:0] k,
   input  logic                   left_in,
   input  logic                   right_in,
   output logic [DATA_WIDTH-1:0]  q_next
);

   localparam int W = DATA_WIDTH;

   logic [W-1:0]   lo_mask;  // the k low bits, vacated by a left shift
   logic [W-1:0]   hi_mask;  // the k high bits, vacated by a right shift
   logic [2*W-1:0] dbl_l;
   logic [2*W-1:0] dbl_r;

   // Select the operation; rotates use a doubled copy so bits wrap around naturally.
   always_comb begin
      // NOTE: q_next gets a value before the case so that no path leaves it unassigned;
      // otherwise synthesis would infer a latch to hold the old value.
      q_next  = q;
      lo_mask = ~({W{1'b1}} << k);
      hi_mask = ~({W{1'b1}} >> k);
      dbl_l   = {q, q} << k;
      dbl_r   = {q, q} >> k;
      case (mode)
         MODE_HOLD: q_next = q;
         MODE_SL:   q_next = (q << k) | (right_in ? lo_mask : '0);
         MODE_SR:   q_next = (q >> k) | (left_in ? hi_mask : '0);
         MODE_ROL:  q_next = dbl_l[2*W-1:W];
         MODE_ROR:  q_next = dbl_r[W-1:0];
         MODE_ASR:  q_next = (q >> k) | (q[W-1] ? hi_mask : '0);
         MODE_SL0:  q_next = q << k;
         MODE_SR0:  q_next = q >> k;
         default:   q_next = q;
      endcase
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with parallel load, single-cycle k-bit operations and a
// burst engine that applies CNT single-bit operations under a START/BUSY/DONE handshake.
// DATA_WIDTH must be at least 2.
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int  DATA_WIDTH  = 8,
   parameter int  CNT_WIDTH   = 8,
   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   LD,
   input  logic [DATA_WIDTH-1:0]  D,
   input  logic                   EN,
   input  logic [2:0]             MODE,
   input  logic [SHAMT_WIDTH-1:0] SHAMT,
   input  logic                   LeftIn,
   input  logic                   RightIn,
   input  logic                   START,
   input  logic [CNT_WIDTH-1:0]   CNT,
   output logic [DATA_WIDTH-1:0]  Q,
   output logic                   MSB_OUT,
   output logic                   LSB_OUT,
   output logic                   BUSY,
   output logic                   DONE
);

   state_e                 state;
   logic [CNT_WIDTH-1:0]   cnt;
   mode_e                  mode_q;
   logic                   done_q;
   logic [DATA_WIDTH-1:0]  q_r;

   logic                   run;
   mode_e                  shift_mode;
   logic [SHAMT_WIDTH-1:0] shift_k;
   logic [DATA_WIDTH-1:0]  q_next;

   // A burst uses the mode captured at START and always moves one bit per edge;
   // otherwise the live MODE/SHAMT inputs drive the single-cycle EN operation.
   assign run        = (state == ST_RUN);
   assign shift_mode = run ? mode_q : mode_e'(MODE);
   assign shift_k    = run ? SHAMT_WIDTH'(1) : SHAMT;

   usr_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_WIDTH(SHAMT_WIDTH)
   ) u_shifter (
      .q       (q_r),
      .mode    (shift_mode),
      .k       (shift_k),
      .left_in (LeftIn),
      .right_in(RightIn),
      .q_next  (q_next)
   );

   // Register, burst counter and FSM: LD beats a burst step, which beats START, which beats EN.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: every state element updates with <= so all of them see the values from
         // before the edge; blocking assignments here would create ordering-dependent logic.
         q_r    <= '0;
         state  <= ST_IDLE;
         cnt    <= '0;
         mode_q <= MODE_HOLD;
         done_q <= 1'b0;
      end else if (LD) begin
         // Load aborts any burst silently.
         q_r    <= D;
         state  <= ST_IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else if (run) begin
         q_r <= q_next;
         cnt <= cnt - CNT_WIDTH'(1);
         if (cnt == CNT_WIDTH'(1)) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
         end else begin
            done_q <= 1'b0;
         end
      end else begin
         done_q <= 1'b0;
         if (START) begin
            if (CNT != '0) begin
               mode_q <= mode_e'(MODE);
               cnt    <= CNT;
               state  <= ST_RUN;
            end else begin
               // Empty burst: report completion straight away.
               done_q <= 1'b1;
            end
         end else if (EN) begin
            q_r <= q_next;
         end
      end
   end

   assign Q       = q_r;
   assign MSB_OUT = q_r[DATA_WIDTH-1];
   assign LSB_OUT = q_r[0];
   assign BUSY    = run;
   assign DONE    = done_q;

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised successor to the team's 5-bit load/shift register. Adds multi-bit barrel shifts, rotates, arithmetic shift and an autonomous burst engine that performs N single-bit shifts under a START/BUSY/DONE handshake. Used for serialisers, LFSR-style scramblers and bit-field alignment in the datapath.

Parameters:
DATA_WIDTH, 8, register width; must be at least 2.
CNT_WIDTH, 8, width of the burst shift count.
SHAMT_WIDTH, $clog2(DATA_WIDTH), localparam derived from DATA_WIDTH; width of the shift amount; not overridable.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
LD  input  1  parallel load of D, highest priority after reset
D  input  DATA_WIDTH  parallel load data
EN  input  1  perform one MODE operation of SHAMT bits this cycle; IDLE state only
MODE  input  3  operation select (see Behaviour)
SHAMT  input  SHAMT_WIDTH  shift amount for EN operations
LeftIn  input  1  fill bit for logical right shifts
RightIn  input  1  fill bit for logical left shifts
START  input  1  begin burst of CNT single-bit MODE operations
CNT  input  CNT_WIDTH  burst length
Q  output  DATA_WIDTH  register contents
MSB_OUT  output  1  Q[DATA_WIDTH-1], combinational
LSB_OUT  output  1  Q[0], combinational
BUSY  output  1  burst in progress
DONE  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (RST_N low, async): Q=0, state=IDLE, counter=0, latched mode=0, BUSY=0, DONE=0.
- MODE encoding, shift by k bits:
  - 000: hold.
  - 001: SL, fill RightIn.
  - 010: SR, fill LeftIn.
  - 011: ROL.
  - 100: ROR.
  - 101: ASR, fill Q[MSB].
  - 110: SL, zero fill.
  - 111: SR, zero fill.
- Fill bit is replicated into all k vacated positions. k=0 leaves Q unchanged.
- SHAMT range is 0..DATA_WIDTH-1. Wider legal values cannot occur.
- Priority per edge: LD > burst step (RUN) > START (IDLE) > EN (IDLE) > hold.
- FSM has two states, IDLE and RUN.
- IDLE, START=1, CNT>0:
  - latch MODE; counter<=CNT; go to RUN.
  - Q is unchanged on this edge, even if EN=1 (START wins).
- IDLE, START=1, CNT=0:
  - no shift; stay in IDLE; DONE=1 for the next cycle.
- RUN, each edge:
  - Q<=latched-mode op with k=1; counter<=counter-1.
  - When counter==1 on that edge: go to IDLE and set DONE=1 for one cycle.
- Timing: START sampled at edge t. Shifts occur at edges t+1..t+CNT. BUSY is high from after t until edge t+CNT. DONE is high for exactly one cycle after t+CNT, with BUSY already low.
- In RUN:
  - START and EN are ignored.
  - MODE changes have no effect (latched copy is used).
  - Latched MODE=000: burst completes with Q held.
- LD in RUN: Q<=D; burst aborts; state=IDLE; BUSY=0 next cycle; no DONE pulse.
- LD in IDLE takes precedence over START and EN; the START is dropped.
- DONE is registered and never high for two consecutive cycles, except back-to-back CNT=0 STARTs.
- Reset asserted mid-burst returns everything to the reset values immediately. No DONE is produced.

Decomposition:
- Package usr_pkg holds MODE constants (MODE_HOLD, MODE_SL, MODE_SR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_SL0, MODE_SR0) and state encoding (ST_IDLE, ST_RUN).
- One sub-module, usr_shifter: purely combinational. Inputs are Q, mode, k, LeftIn, RightIn; output is the next Q. The top level instantiates it once, with k muxed between SHAMT (EN) and 1 (burst).
- Top level holds the FSM, counter and registers.

Test Plan:
- DATA_WIDTH=8. Assert RST_N low mid-operation with Q=0xA5, BUSY=1 -> Q=0x00, BUSY=0, DONE=0 immediately, before the next CLK edge.
- LD D=0x96, then EN MODE=011 SHAMT=3 -> Q=0xB4. Reload 0x96, EN MODE=101 SHAMT=2 -> Q=0xE5.
- Q=0x96, EN MODE=001 SHAMT=2 RightIn=1 -> Q=0x5B. Q=0x96, EN MODE=010 SHAMT=0 -> Q=0x96.
- Q=0x96, START MODE=100 CNT=4 -> Q steps 0x4B, 0xA5, 0xD2, 0x69. BUSY high 4 cycles. DONE pulses once after the last edge. MODE toggled during RUN has no effect.
- Burst MODE=110 CNT=200 from Q=0xFF; LD D=0x3C at step 5 -> Q=0x3C, BUSY falls, no DONE. START with CNT=0 -> DONE one cycle, Q unchanged.
- During RUN assert START and EN together -> both ignored. In IDLE assert LD, START and EN together -> Q=D, no BUSY.
